audio_sample_dac: RTL and testbench
===================================

Name: audio_sample_dac

Overview:
- Consumer end of the voice sample stream.
- Accepts BITDEPTH-bit offset-binary samples over a valid/ready handshake into a small FIFO.
- Pops one sample per sample tick from an internal divider that matches the voice sample clock rate.
- Drives a first-order sigma-delta 1-bit PDM output to the board's audio pin/RC filter.

Parameters:
BITDEPTH, 14, sample width; offset-binary, midscale 2^(BITDEPTH-1) = silence
SAMPLECLOCK_DIV, 8, sample tick every 2^SAMPLECLOCK_DIV clk cycles (31,250 Hz at 8 MHz)
FIFO_AW, 2, FIFO address bits; depth = 2^FIFO_AW = 4

Ports:
clk  in  1  system clock (8 MHz)
rst  in  1  reset, asynchronous, active-low
enable  in  1  1 = run; 0 = flush FIFO, force midscale, refuse input
in_sample  in  BITDEPTH  sample data
in_valid  in  1  sample offered
in_ready  out  1  sample accepted when in_valid && in_ready
underrun_clr  in  1  clears underrun flag
underrun  out  1  sticky: tick found FIFO empty while primed
fifo_level  out  FIFO_AW+1  current FIFO occupancy 0..4
sample_tick  out  1  one-cycle pulse on each sample tick
pdm_out  out  1  PDM bitstream

Behaviour:
Reset (rst=0, async):
- FIFO empty; fifo_level=0; in_ready=0; underrun=0; sample_tick=0; pdm_out=0.
- Tick counter=0; accumulator=0; current sample=midscale (0x2000); primed=0.

Tick counter:
- Free-running 0..2^DIV-1, incremented every clk while enable=1; held at 0 while enable=0.
- sample_tick=1 for the single cycle in which counter == 2^DIV-1; the counter wraps to 0 on that cycle.

Handshake:
- in_ready = enable && (fifo_level < 4), combinational from registered state.
- Push occurs on the clk edge where in_valid && in_ready; fifo_level updates on the same edge.
- When full, in_ready=0, so no push is possible.

Pop on sample_tick:
- If fifo_level>0: head moves to the current-sample register (visible to the modulator from the next cycle).
- If fifo_level==0: current sample is held (last value repeats). If primed=1, underrun is set.
- Simultaneous push and pop: fifo_level unchanged, both occur.
- Push while empty on a tick cycle: the pop sees empty (underrun rule applies); the pushed sample stays in the FIFO for the next tick.

primed:
- Set on the first accepted push after enable rises.
- Cleared when enable=0.

Underrun flag:
- Cleared by underrun_clr=1.
- If set and clear happen in the same cycle, set wins.

Modulator (every clk):
- {carry, acc} = acc + current_sample, in BITDEPTH+1 bits; acc keeps the low BITDEPTH bits.
- pdm_out <= carry (registered, one cycle latency).
- Mean density of pdm_out = sample / 2^BITDEPTH.

enable=0 (synchronous effect):
- FIFO flushed (level 0) on the next edge.
- Current sample forced to midscale; primed=0; underrun retains its value.
- Modulator keeps running, so output is a 50% density square wave (silence).

enable re-asserted:
- Counter restarts from 0; first sample_tick occurs 2^DIV cycles later.

Decomposition:
- Shared package audio_pkg: BITDEPTH, SAMPLECLOCK_DIV, MIDSCALE constant, offset-binary sample typedef. The voice and the mixer use the same package.
- One sub-module, sample_fifo:
  - parameterised width and depth; push/pop/level.
  - pop-on-empty ignored; push-on-full ignored.
  - reset async active-low.
- Tick divider, primed/underrun logic and modulator stay in the top.

Test Plan:
- Reset, enable=1, no input, DIV=8: after 256 cycles sample_tick pulses, repeating every 256 cycles. underrun stays 0 (not primed). pdm_out alternates 0,1 from acc=0 (midscale).
- Push 0x3000 then hold FIFO non-empty: after the next tick, pdm_out has exactly 3 highs per 4 clks steady-state. 0x0000 gives constant 0. 0x3FFF gives 16383 highs per 16384 clks.
- Push 5 samples back-to-back with enable=1: in_ready drops after the 4th; fifo_level=4; the 5th is held until a tick pops, then accepted the following cycle, and fifo_level returns to 4.
- Push one sample, let two ticks pass: second tick sets underrun and the sample repeats. Pulse underrun_clr: flag clears. Clear coincident with an underrun tick: flag stays 1.
- Fill FIFO with 3 samples, drop enable for 1 cycle: fifo_level=0 and current sample=0x2000 next cycle; in_ready=0 during enable=0; underrun unchanged; first tick 256 cycles after enable returns.
- Assert rst low mid-stream (level 2, acc nonzero), asynchronous to clk: all outputs go to reset values immediately; after release, behaviour matches a cold start.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants and the offset-binary sample type.
// Used by the voice, the mixer and this DAC.
package audio_pkg;

  localparam int BITDEPTH        = 14;
  localparam int SAMPLECLOCK_DIV = 8;
  localparam int FIFO_AW         = 2;

  typedef logic [BITDEPTH-1:0] sample_t;

  // Offset-binary silence: only the MSB set.
  localparam sample_t MIDSCALE = {1'b1, {(BITDEPTH-1){1'b0}}};

endpackage

// File: rtl/audio_sample_dac_if.sv
// Valid/ready sample stream into the DAC.
// The producer takes the master modport and the DAC takes the slave modport.
interface audio_sample_dac_if;
  import audio_pkg::*;

  sample_t in_sample;
  logic    in_valid;
  logic    in_ready;

  modport master (output in_sample, output in_valid, input in_ready);
  modport slave  (input in_sample, input in_valid, output in_ready);

endinterface

// File: rtl/audio_sample_dac_fifo.sv
// Small sample FIFO with push/pop/level and a synchronous flush.
// A pop while empty is ignored, and so is a push while full.
module sample_fifo #(
  parameter int WIDTH = 14,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level
);

  localparam int         DEPTH     = 1 << AW;
  localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (level < LEVEL_MAX);
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // The storage array has no reset; only the pointers and the level define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/audio_sample_dac.sv
// Consumer end of the voice sample stream. Samples are buffered, released
// one per sample tick, and converted to 1-bit PDM by a first-order sigma-delta.
module audio_sample_dac
  import audio_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  audio_sample_dac_if.slave    in_bus,
  input  logic                 underrun_clr,
  output logic                 underrun,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 sample_tick,
  output logic                 pdm_out
);

  localparam logic [FIFO_AW:0] FIFO_DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

  logic [SAMPLECLOCK_DIV-1:0] tick_cnt;
  sample_t                    cur_sample;
  sample_t                    fifo_head;
  logic [BITDEPTH-1:0]        acc;
  logic [BITDEPTH:0]          sum;
  logic                       primed;
  logic                       push;
  logic                       pop;
  logic                       fifo_empty;

  // Reset is included so that in_ready is low while the block is held in reset.
  assign in_bus.in_ready = rst && enable && (fifo_level < FIFO_DEPTH);
  assign push            = in_bus.in_valid && in_bus.in_ready;
  assign fifo_empty      = (fifo_level == '0);
  assign sample_tick     = enable && (tick_cnt == '1);
  assign pop             = sample_tick && !fifo_empty;
  assign sum             = {1'b0, acc} + {1'b0, cur_sample};

  sample_fifo #(
    .WIDTH (BITDEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (!enable),
    .push  (push),
    .pop   (pop),
    .wdata (in_bus.in_sample),
    .head  (fifo_head),
    .level (fifo_level)
  );

  // The counter wraps naturally at 2^DIV, so the tick cycle also restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        tick_cnt <= '0;
    else if (enable) tick_cnt <= tick_cnt + 1'b1;
    else             tick_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_sample <= MIDSCALE;
      primed     <= 1'b0;
    end else if (!enable) begin
      cur_sample <= MIDSCALE;
      primed     <= 1'b0;
    end else begin
      if (pop)  cur_sample <= fifo_head;
      if (push) primed     <= 1'b1;
    end
  end

  // When an underrun and a clear land in the same cycle, the set takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    underrun <= 1'b0;
    else if (sample_tick && fifo_empty && primed) underrun <= 1'b1;
    else if (underrun_clr)                       underrun <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else begin
      acc     <= sum[BITDEPTH-1:0];
      pdm_out <= sum[BITDEPTH];
    end
  end

endmodule

// File: tb/tb_audio_sample_dac.sv
// Directed test of audio_sample_dac: tick timing, handshake, underrun,
// PDM density, enable flush and asynchronous reset.
module tb_audio_sample_dac;
  import audio_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            underrun_clr;
  logic            underrun;
  logic [FIFO_AW:0] fifo_level;
  logic            sample_tick;
  logic            pdm_out;

  int      tests_run    = 0;
  int      tests_failed = 0;
  int      highs;
  logic    p0;
  logic    p_exp;
  sample_t burst [5] = '{14'h1000, 14'h1100, 14'h1200, 14'h1300, 14'h1400};

  audio_sample_dac_if bus();

  audio_sample_dac dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_bus       (bus.slave),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .sample_tick  (sample_tick),
    .pdm_out      (pdm_out)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic count_pdm(input int n, output int h);
    h = 0;
    repeat (n) begin
      step();
      if (pdm_out === 1'b1) h++;
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (sample_tick !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    check("tick_wait", 32'(sample_tick), 1);
  endtask

  task automatic push(input sample_t s);
    bus.in_sample = s;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; underrun_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_sample = '0;
    #12;
    check("rst_level",    32'(fifo_level), 0);
    check("rst_ready",    32'(bus.in_ready), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_tick",     32'(sample_tick), 0);
    check("rst_pdm",      32'(pdm_out), 0);

    // Midscale from acc=0 produces 0,1,0,...
    rst = 1'b1;
    step(); check("mid_pdm0", 32'(pdm_out), 0);
    step(); check("mid_pdm1", 32'(pdm_out), 1);
    step(); check("mid_pdm2", 32'(pdm_out), 0);

    enable = 1'b1;
    #1;
    check("ready_on", 32'(bus.in_ready), 1);
    step(254); check("tick_early", 32'(sample_tick), 0);
    step();    check("tick_first", 32'(sample_tick), 1);
    step();    check("tick_pulse", 32'(sample_tick), 0);
    check("unprimed_underrun", 32'(underrun), 0);
    step(255); check("tick_period", 32'(sample_tick), 1);
    step();    check("unprimed_pop", 32'(underrun), 0);

    push(14'h3000); push(14'h0000); push(14'h3FFF); push(14'h3000);
    check("fill_level", 32'(fifo_level), 4);

    wait_tick(); step();
    check("pop_level", 32'(fifo_level), 3);
    count_pdm(8, highs); check("density_3000", highs, 6);
    wait_tick(); step();
    count_pdm(8, highs); check("density_0000", highs, 0);
    wait_tick(); step();
    count_pdm(16, highs); check("density_3fff", 32'(highs >= 15), 1);
    wait_tick(); step();
    check("last_pop_underrun", 32'(underrun), 0);
    check("empty_level", 32'(fifo_level), 0);

    // Tick with an empty FIFO after priming; the last sample keeps playing.
    wait_tick(); step();
    check("underrun_set", 32'(underrun), 1);
    count_pdm(8, highs); check("repeat_sample", highs, 6);
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    check("underrun_clr", 32'(underrun), 0);
    wait_tick();
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    check("set_wins", 32'(underrun), 1);

    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_sample = burst[i];
      step();
    end
    check("burst_level", 32'(fifo_level), 4);
    check("burst_ready", 32'(bus.in_ready), 0);
    bus.in_sample = burst[4];
    wait_tick();
    check("held_full", 32'(bus.in_ready), 0);
    step();
    check("burst_pop_level", 32'(fifo_level), 3);
    check("burst_pop_ready", 32'(bus.in_ready), 1);
    step();
    check("burst_refill", 32'(fifo_level), 4);
    bus.in_valid = 1'b0;

    enable = 1'b0;
    #1;
    check("dis_ready", 32'(bus.in_ready), 0);
    step();
    check("dis_flush", 32'(fifo_level), 0);
    check("dis_underrun_kept", 32'(underrun), 1);
    enable = 1'b1;
    step(); p0 = pdm_out;
    p_exp = ~p0;
    step(); check("dis_mid_alt1", 32'(pdm_out), 32'(p_exp));
    step(); check("dis_mid_alt2", 32'(pdm_out), 32'(p0));
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    check("reen_clr", 32'(underrun), 0);
    step(250); check("reen_tick_early", 32'(sample_tick), 0);
    step();    check("reen_tick", 32'(sample_tick), 1);
    step();    check("primed_cleared", 32'(underrun), 0);

    push(14'h2800); push(14'h2800);
    check("pre_reset_level", 32'(fifo_level), 2);
    #3 rst = 1'b0;
    #1;
    check("arst_level", 32'(fifo_level), 0);
    check("arst_ready", 32'(bus.in_ready), 0);
    check("arst_pdm",   32'(pdm_out), 0);
    check("arst_tick",  32'(sample_tick), 0);
    step(2);
    rst = 1'b1;
    step(); check("cold_pdm0", 32'(pdm_out), 0);
    step(); check("cold_pdm1", 32'(pdm_out), 1);
    step(252); check("cold_tick_early", 32'(sample_tick), 0);
    step();    check("cold_tick", 32'(sample_tick), 1);
    check("cold_underrun", 32'(underrun), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
